// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Request/result bundle for the bit-serial subtractor.
//
// Handshake: the master raises start with A/B valid; the slave accepts on the
// first rising clk edge at which it is idle and start=1, latching A/B on that
// edge only. A and B are don't-care afterwards. busy stays high for WIDTH
// cycles while bits are processed. done pulses high for exactly one cycle once
// C/borrow_out/zero hold the new result. start is ignored while busy or done;
// requests are never queued.
//
// Signals:
//   start      master->slave  request, sampled only when idle
//   A, B       master->slave  minuend / subtrahend
//   busy       slave->master  bits being processed
//   done       slave->master  one-cycle completion pulse
//   C          slave->master  difference register
//   borrow_out slave->master  A < B (unsigned)
//   zero       slave->master  C == 0
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] C;
  logic             borrow_out;
  logic             zero;

  modport master (
    output start, A, B,
    input  busy, done, C, borrow_out, zero
  );

  modport slave (
    input  start, A, B,
    output busy, done, C, borrow_out, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor: C = (A - B) mod 2^WIDTH, one bit per clock, LSB
// first, with borrow_out = (A < B) and zero = (C == 0).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   bus          serial_subtractor_if.slave (start/A/B in, busy/done/C/
//                borrow_out/zero out)
//   o_dbg_state  current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Timing: start accepted at edge k -> busy for cycles k+1..k+WIDTH, results
// update at edge k+WIDTH, done high for the following cycle only.
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output logic [1:0]           o_dbg_state
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_bin;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_c;
  logic             r_borrow;
  logic             r_zero;

  logic             w_a0;
  logic             w_b0;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

  // Full-subtractor cell on the current LSBs.
  assign w_a0       = r_a[0];
  assign w_b0       = r_b[0];
  assign w_d        = w_a0 ^ w_b0 ^ r_bin;
  assign w_bout     = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & r_bin);
  // Difference bits enter at the MSB so after WIDTH shifts bit 0 sits at LSB.
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_bin    <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_c      <= '0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a     <= bus.A;
            r_b     <= bus.B;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_res <= w_res_next;
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_bin <= w_bout;
          r_cnt <= r_cnt + 1'b1;
          // Visible outputs change only here, so partial results never leak.
          if (w_last) begin
            r_c      <= w_res_next;
            r_borrow <= w_bout;
            r_zero   <= (w_res_next == '0);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.C          = r_c;
  assign bus.borrow_out = r_borrow;
  assign bus.zero       = r_zero;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [1:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(W)) ifc ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (ifc.slave),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] exp_q[$];   // {borrow, difference}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] d;
    d = a - b;
    return {(a < b), d};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.A     = '0;
    ifc.B     = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Call from a negedge while the DUT is idle; returns just after the accepting edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    ifc.A     = a;
    ifc.B     = b;
    ifc.start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk);
  endtask

  // Waits for done; meddle=1 raises start with junk operands mid-operation.
  task automatic wait_done(input bit meddle, output int cycles, output int busy_cnt,
                           output bit held);
    logic [W-1:0] c0;
    c0       = ifc.C;
    cycles   = 0;
    busy_cnt = 0;
    held     = 1'b1;
    while (cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (ifc.busy) busy_cnt++;
      if (ifc.busy && ifc.C !== c0) held = 1'b0;
      if (ifc.done) break;
      if (meddle && cycles >= 3 && cycles <= 5) begin
        ifc.start = 1'b1;
        ifc.A     = (cycles == 3) ? 8'h55 : W'($urandom);
        ifc.B     = (cycles == 3) ? 8'h11 : W'($urandom);
      end else begin
        ifc.start = 1'b0;
      end
    end
    ifc.start = 1'b0;
  endtask

  task automatic check_result(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_C"},      32'(ifc.C),          32'(e[W-1:0]));
    check({tag, "_borrow"}, 32'(ifc.borrow_out), 32'(e[W]));
    check({tag, "_zero"},   32'(ifc.zero),       32'(e[W-1:0] == '0));
  endtask

  // Full directed op: latency, busy length, hold, result, done width.
  task automatic directed_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input bit meddle);
    int cyc, bc;
    bit held;
    start_op(a, b);
    wait_done(meddle, cyc, bc, held);
    check({tag, "_done_lat"}, 32'(cyc), 32'(W + 1));
    check({tag, "_busy_len"}, 32'(bc), 32'(W));
    check({tag, "_hold"}, 32'(held), 32'd1);
    check_result(tag);
    @(negedge clk);
    check({tag, "_done_fall"}, 32'(ifc.done), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dn, cyc, ov;
    logic [W-1:0] a, b;

    do_reset();
    check("rst_C",      32'(ifc.C),          32'd0);
    check("rst_zero",   32'(ifc.zero),       32'd1);
    check("rst_borrow", 32'(ifc.borrow_out), 32'd0);
    check("rst_busy",   32'(ifc.busy),       32'd0);
    check("rst_done",   32'(ifc.done),       32'd0);
    check("rst_state",  32'(dbg_state),      32'd0);

    directed_op("eq02",  8'h02, 8'h02, 1'b0);
    directed_op("s03_01", 8'h03, 8'h01, 1'b0);
    directed_op("s92_ab", 8'h92, 8'hAB, 1'b0);
    directed_op("s00_01", 8'h00, 8'h01, 1'b0);
    directed_op("sff_ff", 8'hFF, 8'hFF, 1'b0);

    // Mid-busy start must be ignored.
    directed_op("ignore", 8'h10, 8'h01, 1'b1);
    dn = 0;
    repeat (15) begin
      @(negedge clk);
      if (ifc.done) dn++;
    end
    check("ignore_extra_done", 32'(dn), 32'd0);

    // Reset mid-operation.
    start_op(8'h40, 8'h01);
    ifc.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_C",      32'(ifc.C),          32'd0);
    check("abort_zero",   32'(ifc.zero),       32'd1);
    check("abort_borrow", 32'(ifc.borrow_out), 32'd0);
    check("abort_busy",   32'(ifc.busy),       32'd0);
    check("abort_done",   32'(ifc.done),       32'd0);
    void'(exp_q.pop_back());
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (ifc.done) dn++;
    end
    check("abort_no_done", 32'(dn), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    directed_op("after_rst", 8'h20, 8'h05, 1'b0);

    // Random sweep, start held high; operands scrambled while busy.
    a = W'($urandom);
    b = W'($urandom);
    ifc.A     = a;
    ifc.B     = b;
    ifc.start = 1'b1;
    exp_q.push_back(model(a, b));
    for (int i = 0; i < 1000; i++) begin
      cyc = 0;
      ov  = 0;
      while (cyc < 40) begin
        @(negedge clk);
        cyc++;
        if (ifc.busy && ifc.done) ov++;
        if (ifc.done) break;
        if (ifc.busy) begin
          ifc.A = W'($urandom);
          ifc.B = W'($urandom);
        end
      end
      check_result("sweep");
      check("sweep_overlap", 32'(ov), 32'd0);
      if (i > 0) check("sweep_period", 32'(cyc), 32'(W + 2));
      if (i < 999) begin
        a = W'($urandom_range(0, 255));
        b = (i % 7 == 0) ? a : W'($urandom_range(0, 255));
        ifc.A = a;
        ifc.B = b;
        exp_q.push_back(model(a, b));
      end
    end
    ifc.start = 1'b0;
    repeat (3) @(negedge clk);

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial subtractor computing C = A - B (mod 2^WIDTH) with a borrow flag. It processes one bit per clock, LSB first, and uses a start/busy/done handshake. It is the inverse-direction companion to the team's combinational ripple adder and is the sequential arithmetic block for datapaths where area matters more than latency. Results must match the adder's output for the inputs A and (~B + 1), modulo 2^WIDTH.

Parameters:
WIDTH, 8, operand and result width in bits (must be 2 or greater).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
A  input  WIDTH  minuend; sampled on the accepting edge only
B  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high while bits are being processed
done  output  1  single-cycle pulse when the result is valid and updated
C  output  WIDTH  difference register
borrow_out  output  1  high when A < B (unsigned)
zero  output  1  high when C == 0

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, C=0, borrow_out=0, zero=1; internal shift registers, borrow and bit counter cleared.
- FSM states and transitions:
  - IDLE -> BUSY on a clk edge with start=1. The same edge latches A and B into shift registers, sets internal borrow to 0 and sets the bit counter to 0.
  - BUSY: each edge computes d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin) on the current LSBs.
    - d shifts into the MSB of the result shift register; the operand registers shift right; bin <= bout; counter increments.
    - On the edge that processes bit WIDTH-1: C <= final result, borrow_out <= final bout, zero <= (result == 0), then go to DONE.
  - DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Latency: if start is accepted at edge k, busy is high for cycles k+1 .. k+WIDTH (WIDTH cycles). C, borrow_out and zero update at edge k+WIDTH. done is high in the cycle after edge k+WIDTH, then falls.
- busy=1 only in BUSY; done=1 only in DONE; the two are never high together.
- C, borrow_out and zero hold their previous values throughout BUSY; partial results are never visible. All three hold after DONE until the next completion.
- start is ignored in BUSY and DONE; it is not queued. Back-to-back operation requires start in the IDLE cycle after done, giving WIDTH+2 cycles per operation minimum.
- A and B may change freely after the accepting edge without affecting the result.
- Arithmetic: C = (A - B) mod 2^WIDTH; borrow_out = (A < B) unsigned. Equal operands give C=0, zero=1, borrow_out=0.
- Reset mid-operation: abort immediately, return to reset values, produce no done pulse. The first start after rst_n rises is accepted normally.
- start held high continuously: a new operation begins on the first edge in IDLE after each DONE.

Test Plan:
1. After reset, check C=0, zero=1, borrow_out=0, busy=0, done=0. Then A=8'h02, B=8'h02, pulse start -> after 8 busy cycles, one-cycle done pulse with C=8'h00, zero=1, borrow_out=0.
2. A=8'h03, B=8'h01 -> C=8'h02, borrow_out=0, zero=0; done rises exactly 9 cycles after the start edge (WIDTH+1) and lasts 1 cycle.
3. A=8'h92, B=8'hAB -> C=8'hE7, borrow_out=1. Also A=8'h00, B=8'h01 -> C=8'hFF, borrow_out=1. Also A=8'hFF, B=8'hFF -> C=8'h00, zero=1.
4. Start an operation (A=8'h10, B=8'h01). Mid-BUSY, assert start with A=8'h55, B=8'h11 and toggle A/B -> the request is ignored; the result is C=8'h0F; exactly one done pulse.
5. Assert rst_n low at cycle 4 of BUSY -> outputs return to reset values at once and no done pulse appears. After release, A=8'h20, B=8'h05 -> C=8'h1B.
6. Random sweep of 1000 operand pairs with start held high -> each C equals (A - B) mod 256, borrow_out equals (A < B), the done period is 10 cycles, and busy and done are never high together.
